// File: rtl/btn_event_decoder.sv
// Button event decoder.
// Turns a debounced, clock-synchronous button level into one-cycle UI
// event strobes: press, release, short click, long press and auto-repeat.
// It also provides two level outputs: "held" and "long held".
// Every output is driven straight from a flop.
module btn_event_decoder #(
    parameter int unsigned LONG_CNT   = 32'd50000,
    parameter int unsigned REPEAT_CNT = 32'd10000,
    parameter bit          REPEAT_EN  = 1'b1,
    parameter int unsigned CNT_W      = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_press,
    output logic o_release,
    output logic o_short,
    output logic o_long,
    output logic o_repeat,
    output logic o_held,
    output logic o_long_held
);

    // The counter only ever counts up to threshold-1, so comparing against
    // the truncated last value is exact and no wrap can occur.
    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CNT - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CNT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        LONG    = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             short_q, short_d;
    logic             long_q, long_d;
    logic             rpt_q, rpt_d;
    logic             held_q, held_d;
    logic             long_held_q, long_held_d;

    // Next-state, counter and output-strobe decode. Pulses default to 0.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        short_d   = 1'b0;
        long_d    = 1'b0;
        rpt_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_btn) begin
                    press_d = 1'b1;
                    cnt_d   = '0;
                    state_d = PRESSED;
                end
            end
            PRESSED: begin
                // A release on the threshold edge wins over the long event.
                if (!i_btn) begin
                    release_d = 1'b1;
                    short_d   = 1'b1;
                    state_d   = IDLE;
                end else if (cnt_q == LONG_LAST) begin
                    long_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = LONG;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LONG: begin
                // A release on the repeat edge wins over the repeat event.
                if (!i_btn) begin
                    release_d = 1'b1;
                    state_d   = IDLE;
                end else if (REPEAT_EN) begin
                    if (cnt_q == REPEAT_LAST) begin
                        rpt_d = 1'b1;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        held_d      = (state_d != IDLE);
        long_held_d = (state_d == LONG);
    end

    // State, counter and output registers. Reset aborts any event in flight.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            short_q     <= 1'b0;
            long_q      <= 1'b0;
            rpt_q       <= 1'b0;
            held_q      <= 1'b0;
            long_held_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            press_q     <= press_d;
            release_q   <= release_d;
            short_q     <= short_d;
            long_q      <= long_d;
            rpt_q       <= rpt_d;
            held_q      <= held_d;
            long_held_q <= long_held_d;
        end
    end

    assign o_press     = press_q;
    assign o_release   = release_q;
    assign o_short     = short_q;
    assign o_long      = long_q;
    assign o_repeat    = rpt_q;
    assign o_held      = held_q;
    assign o_long_held = long_held_q;

endmodule

// File: tb/tb_btn_event_decoder.sv
// Testbench for btn_event_decoder.
// Two instances share one stimulus: unit A has repeat enabled, unit B has
// it disabled. Both use LONG_CNT=8 and REPEAT_CNT=4.
// Output vectors are packed as
// {press, release, short, long, repeat, held, long_held}.
module tb_btn_event_decoder;

    localparam int L = 8;
    localparam int R = 4;

    logic clk = 1'b0;
    logic rst;
    logic btn;

    logic a_press, a_release, a_short, a_long, a_repeat, a_held, a_long_held;
    logic b_press, b_release, b_short, b_long, b_repeat, b_held, b_long_held;

    btn_event_decoder #(
        .LONG_CNT(L), .REPEAT_CNT(R), .REPEAT_EN(1'b1), .CNT_W(16)
    ) dut_a (
        .i_clk(clk), .i_rst(rst), .i_btn(btn),
        .o_press(a_press), .o_release(a_release), .o_short(a_short),
        .o_long(a_long), .o_repeat(a_repeat), .o_held(a_held),
        .o_long_held(a_long_held)
    );

    btn_event_decoder #(
        .LONG_CNT(L), .REPEAT_CNT(R), .REPEAT_EN(1'b0), .CNT_W(16)
    ) dut_b (
        .i_clk(clk), .i_rst(rst), .i_btn(btn),
        .o_press(b_press), .o_release(b_release), .o_short(b_short),
        .o_long(b_long), .o_repeat(b_repeat), .o_held(b_held),
        .o_long_held(b_long_held)
    );

    always #5 clk = ~clk;

    logic [6:0] out_a, out_b;
    assign out_a = {a_press, a_release, a_short, a_long, a_repeat, a_held, a_long_held};
    assign out_b = {b_press, b_release, b_short, b_long, b_repeat, b_held, b_long_held};

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: for each unit, whether the button is held and how
    // many edges have passed since the press edge.
    bit         m_held [2];
    int         m_t    [2];
    logic [6:0] m_exp  [2];

    typedef struct {
        logic       btn;
        logic [6:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_held[d] = 1'b0;
            m_t[d]    = 0;
            m_exp[d]  = '0;
        end
    endtask

    // Apply the event rules directly, in terms of hold time since the press.
    task automatic model_edge(input int d, input logic b);
        logic [6:0] e;
        bit rep_en;
        e      = '0;
        rep_en = (d == 0);
        if (!m_held[d]) begin
            if (b) begin
                e[6]      = 1'b1;
                m_held[d] = 1'b1;
                m_t[d]    = 0;
            end
        end else if (b) begin
            m_t[d]++;
            if (m_t[d] == L)
                e[3] = 1'b1;
            else if (rep_en && m_t[d] > L && ((m_t[d] - L) % R) == 0)
                e[2] = 1'b1;
        end else begin
            e[5] = 1'b1;
            if (m_t[d] < L) e[4] = 1'b1;
            m_held[d] = 1'b0;
        end
        e[1]     = m_held[d];
        e[0]     = m_held[d] && (m_t[d] >= L);
        m_exp[d] = e;
    endtask

    // Drive one button sample, clock it, then check both units against the model.
    task automatic step(input logic b);
        btn = b;
        @(posedge clk);
        #1;
        model_edge(0, b);
        model_edge(1, b);
        chk("model_a", out_a, m_exp[0]);
        chk("model_b", out_b, m_exp[1]);
    endtask

    // Assert reset between clock edges and check that the outputs clear at once.
    task automatic async_reset_check(input string name);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk(name, out_a, 7'b0);
        chk(name, out_b, 7'b0);
    endtask

    vec_t vecs [11];
    int   n_long_seen;
    int   n_rep_seen;
    logic val;
    int   len;

    initial begin
        // Short clicks and back-to-back press/release, expected values written out by hand.
        vecs[0]  = '{1'b0, 7'b0000000};
        vecs[1]  = '{1'b1, 7'b1000010};
        vecs[2]  = '{1'b1, 7'b0000010};
        vecs[3]  = '{1'b1, 7'b0000010};
        vecs[4]  = '{1'b0, 7'b0110000};
        vecs[5]  = '{1'b0, 7'b0000000};
        vecs[6]  = '{1'b1, 7'b1000010};
        vecs[7]  = '{1'b0, 7'b0110000};
        vecs[8]  = '{1'b1, 7'b1000010};
        vecs[9]  = '{1'b0, 7'b0110000};
        vecs[10] = '{1'b0, 7'b0000000};

        rst = 1'b1;
        btn = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_a", out_a, 7'b0);
        chk("reset_b", out_b, 7'b0);
        rst = 1'b0;

        // Idle for 20 cycles: nothing may fire.
        for (int k = 0; k < 20; k++) begin
            step(1'b0);
            chk("idle_a", out_a, 7'b0);
        end

        for (int i = 0; i < 11; i++) begin
            step(vecs[i].btn);
            chk($sformatf("vec%0d_a", i), out_a, vecs[i].exp);
            chk($sformatf("vec%0d_b", i), out_b, vecs[i].exp);
        end

        // Hold for 18 edges: long at P+8, repeats at P+12 and P+16 on A only.
        for (int k = 0; k < 18; k++) begin
            step(1'b1);
            chk($sformatf("hold18_a_k%0d", k), out_a,
                {k == 0, 2'b00, k == 8, (k == 12) || (k == 16), 1'b1, k >= 8});
            chk($sformatf("hold18_b_k%0d", k), out_b,
                {k == 0, 2'b00, k == 8, 1'b0, 1'b1, k >= 8});
        end
        step(1'b0);
        chk("long_release_a", out_a, 7'b0100000);
        chk("long_release_b", out_b, 7'b0100000);
        step(1'b0);

        // Release on the exact edge that would have produced the long event.
        n_long_seen = 0;
        for (int k = 0; k < 8; k++) begin
            step(1'b1);
            if (a_long || a_long_held) n_long_seen++;
        end
        step(1'b0);
        if (a_long || a_long_held) n_long_seen++;
        chk("edge_release_a", out_a, 7'b0110000);
        n_tests++;
        if (n_long_seen != 0) begin
            n_fail++;
            $display("FAIL edge_no_long: got %0d long cycles expected 0", n_long_seen);
        end
        step(1'b0);

        // Asynchronous reset while in the long-held state, then a press on the first edge.
        for (int k = 0; k < 10; k++) step(1'b1);
        chk("pre_reset_long_a", out_a, 7'b0000011);
        async_reset_check("reset_in_long");
        btn = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        step(1'b1);
        chk("press_after_reset_a", out_a, 7'b1000010);
        chk("press_after_reset_b", out_b, 7'b1000010);
        step(1'b0);
        step(1'b0);

        // Hold for 30 edges: B (repeat disabled) shows long only, with no repeats.
        n_rep_seen = 0;
        for (int k = 0; k < 30; k++) begin
            step(1'b1);
            if (b_repeat) n_rep_seen++;
            chk($sformatf("hold30_b_k%0d", k), out_b,
                {k == 0, 2'b00, k == 8, 1'b0, 1'b1, k >= 8});
        end
        n_tests++;
        if (n_rep_seen != 0) begin
            n_fail++;
            $display("FAIL norepeat_count: got %0d repeats expected 0", n_rep_seen);
        end
        step(1'b0);
        chk("hold30_release_b", out_b, 7'b0100000);

        // Randomised runs of held and released levels, with occasional resets.
        val = 1'b0;
        for (int r = 0; r < 160; r++) begin
            len = int'($urandom_range(1, 26));
            val = ($urandom_range(0, 9) == 0) ? val : ~val;
            for (int k = 0; k < len; k++) step(val);
            if ($urandom_range(0, 24) == 0) begin
                async_reset_check("rand_reset");
                @(negedge clk);
                rst = 1'b0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/btn_event_decoder.md
Name: btn_event_decoder

Overview:
- Consumes the debounced, level-valid button signal from the front-panel debounce stage.
- Converts it into single-cycle UI event strobes: press, release, short click, long press and auto-repeat.
- Sits between the button conditioning and the scope control logic (timebase, trigger level and channel select), so every control handler receives clean one-cycle events instead of polling levels.

Parameters:
- LONG_CNT, 16'd50000, hold duration in i_clk cycles from o_press to o_long. Legal range 2..2^CNT_W.
- REPEAT_CNT, 16'd10000, period in i_clk cycles between o_repeat pulses after o_long. Legal range 2..2^CNT_W.
- REPEAT_EN, 1, 1 = generate o_repeat while held past long; 0 = no repeat pulses.
- CNT_W, 16, width of the hold/repeat counter.

Ports:
- i_clk  input  1  clock
- i_rst  input  1  reset; asynchronous, active-high
- i_btn  input  1  debounced button level (1 = pressed); already synchronous to i_clk
- o_press  output  1  one-cycle pulse on press
- o_release  output  1  one-cycle pulse on release
- o_short  output  1  one-cycle pulse on release before long threshold
- o_long  output  1  one-cycle pulse when hold reaches LONG_CNT
- o_repeat  output  1  one-cycle pulse every REPEAT_CNT cycles after o_long
- o_held  output  1  level: button considered held (state != IDLE)
- o_long_held  output  1  level: state == LONG

Behaviour:
- Reset: i_rst is asynchronous, active-high; clock is i_clk.
  - State = IDLE, cnt = 0, all outputs 0.
  - Assertion mid-operation aborts immediately with no release or short pulse.
- All outputs are registered. Pulse outputs default to 0 every cycle unless set below.
- FSM states are IDLE, PRESSED and LONG. i_btn is sampled at each rising i_clk edge.
- IDLE:
  - i_btn=1 -> o_press=1, cnt<=0, next PRESSED.
  - i_btn=1 on the first edge after reset counts as a press.
  - i_btn=0 -> stay.
- PRESSED:
  - i_btn=0 -> o_release=1 and o_short=1 in the same cycle, next IDLE.
  - i_btn=1 and cnt==LONG_CNT-1 -> o_long=1, cnt<=0, next LONG.
  - Otherwise cnt<=cnt+1.
- LONG:
  - i_btn=0 -> o_release=1 (o_short stays 0), next IDLE.
  - i_btn=1 and REPEAT_EN and cnt==REPEAT_CNT-1 -> o_repeat=1, cnt<=0.
  - i_btn=1 otherwise -> cnt<=cnt+1 if REPEAT_EN, hold if not.
- Timing, with o_press high in the cycle after edge P:
  - o_long is high after edge P+LONG_CNT.
  - o_repeat is high after edges P+LONG_CNT+n*REPEAT_CNT, n>=1.
- Simultaneous events: release on the edge where cnt==LONG_CNT-1 produces o_release+o_short only, never o_long. Release on the repeat edge produces o_release only.
- Mutual exclusion: at most one of o_press/o_long/o_repeat per cycle. o_short is only ever high together with o_release.
- Back-to-back: release then i_btn=1 on the very next edge gives o_release at edge R and o_press at edge R+1. Minimum press/release spacing is 1 cycle.
- o_held = (state != IDLE), registered with the state. It rises with o_press and falls with o_release.
- o_long_held = (state == LONG). It rises with o_long.
- Counter arithmetic: unsigned CNT_W bits. Comparisons against LONG_CNT-1 and REPEAT_CNT-1 are truncated to CNT_W. The counter never exceeds the threshold-1, so no wrap occurs.

Test Plan (override LONG_CNT=8, REPEAT_CNT=4, REPEAT_EN=1):
- Reset with i_btn=0, then hold 0 for 20 cycles -> all outputs 0, o_held=0.
- i_btn=1 for 3 cycles, then 0 -> o_press at P, o_release+o_short together at P+3, o_held high P..P+2, no o_long.
- i_btn=1 for 18 cycles -> o_press at P, o_long at P+8, o_repeat at P+12 and P+16, then release -> o_release only, no o_short.
- i_btn drops on the exact cycle that would give o_long (held 8 edges incl. press) -> o_short+o_release, o_long never asserted, o_long_held stays 0.
- Assert i_rst while in LONG -> all outputs 0 immediately. After release of reset with i_btn=1 -> o_press on the first clock edge.
- REPEAT_EN=0 build, hold 30 cycles -> o_long at P+8, zero o_repeat pulses, o_long_held=1 until release.
